// File: rtl/udp_buf_pkg.sv
// Shared types and constants for the UDP payload ping-pong buffer.
package udp_buf_pkg;
  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY, R_GAP} rd_state_t;
  localparam int WORD_BYTES = 4;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/udp_payload_buffer_if.sv
// Bundle of sample-input, sender-handshake and status signals around the payload buffer.
interface udp_payload_buffer_if #(parameter int ADDR_W = 11);
  logic                               in_valid;
  logic [31:0]                        in_data;
  logic                               in_last;
  logic [7:0]                         in_channel;
  logic [31:0]                        time_now;
  logic                               tx_start;
  logic [15:0]                        tx_length;
  logic [31:0]                        tx_time;
  logic [7:0]                         tx_channel;
  logic [ADDR_W-1:0]                  rd_adr;
  logic [31:0]                        rd_data;
  logic                               tx_done;
  logic                               overflow;
  logic [udp_buf_pkg::DROP_CNT_W-1:0] drop_cnt;
  logic                               tx_timeout;

  modport master (
    output in_valid, in_data, in_last, in_channel, time_now, rd_adr, tx_done,
    input  tx_start, tx_length, tx_time, tx_channel, rd_data, overflow, drop_cnt, tx_timeout
  );
  modport slave (
    input  in_valid, in_data, in_last, in_channel, time_now, rd_adr, tx_done,
    output tx_start, tx_length, tx_time, tx_channel, rd_data, overflow, drop_cnt, tx_timeout
  );
endinterface

// File: rtl/udp_buf_dpram.sv
// Two-bank simple dual-port RAM; address is {bank, word}, read data registered.
module udp_buf_dpram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
endmodule

// File: rtl/udp_payload_buffer.sv
// Ping-pong payload store feeding the UDP frame sender.
// Optional watchdog on the sender's end-of-transmit: define UDP_BUF_TIMEOUT_EN.
module udp_payload_buffer
  import udp_buf_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int PKT_WORDS   = 256,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  udp_payload_buffer_if.slave  bus
);
  localparam int CW = ADDR_W + 1;

  wr_state_t              wr_st, wr_nxt;
  rd_state_t              rd_st, rd_nxt;
  logic                   wb, rb;
  logic [1:0]             bank_full, set_m, clr_m;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [ADDR_W-1:0]      wr_word;
  logic                   wr_en, close, drop, load, rel, wd_hit;
  logic [1:0][15:0]       len_q;
  logic [1:0][31:0]       time_q;
  logic [1:0][7:0]        ch_q;
  logic [15:0]            tx_length_q;
  logic [31:0]            tx_time_q;
  logic [7:0]             tx_channel_q;
  logic                   overflow_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;

  // Only W_IDLE can see a full write bank: a bank in W_FILL was empty when opened.
  always_comb begin
    wr_nxt  = wr_st;
    wr_en   = 1'b0;
    drop    = 1'b0;
    close   = 1'b0;
    cnt_nxt = cnt;
    wr_word = '0;
    case (wr_st)
      W_IDLE: if (bus.in_valid) begin
        if (bank_full[wb]) drop = 1'b1;
        else begin
          wr_en   = 1'b1;
          cnt_nxt = CW'(1);
          wr_nxt  = W_FILL;
        end
      end
      W_FILL: if (bus.in_valid) begin
        wr_en   = 1'b1;
        wr_word = cnt[ADDR_W-1:0];
        cnt_nxt = cnt + 1'b1;
      end
      default: ;
    endcase
    if ((wr_en || wr_st == W_FILL) && (cnt_nxt == CW'(PKT_WORDS) || bus.in_last)) begin
      close  = 1'b1;
      wr_nxt = W_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_st      <= W_IDLE;
      wb         <= 1'b0;
      cnt        <= '0;
      len_q      <= '0;
      time_q     <= '0;
      ch_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_st <= wr_nxt;
      cnt   <= cnt_nxt;
      if (wr_en && wr_st == W_IDLE) begin
        time_q[wb] <= bus.time_now;
        ch_q[wb]   <= bus.in_channel;
      end
      if (close) begin
        len_q[wb] <= 16'(cnt_nxt * WORD_BYTES);
        wb        <= ~wb;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end

  always_comb begin
    rd_nxt = rd_st;
    load   = 1'b0;
    rel    = 1'b0;
    case (rd_st)
      R_IDLE:  if (bank_full[rb]) begin load = 1'b1; rd_nxt = R_START; end
      R_START: rd_nxt = R_BUSY;
      R_BUSY:  if (bus.tx_done || wd_hit) begin rel = 1'b1; rd_nxt = R_GAP; end
      R_GAP:   rd_nxt = R_IDLE;
      default: rd_nxt = R_IDLE;
    endcase
  end

  // Close and release always hit different banks, so both masks apply together.
  assign set_m = {close & wb, close & ~wb};
  assign clr_m = {rel & rb, rel & ~rb};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_st        <= R_IDLE;
      rb           <= 1'b0;
      bank_full    <= '0;
      tx_length_q  <= '0;
      tx_time_q    <= '0;
      tx_channel_q <= '0;
    end else begin
      rd_st     <= rd_nxt;
      bank_full <= (bank_full | set_m) & ~clr_m;
      if (rel) rb <= ~rb;
      if (load) begin
        tx_length_q  <= len_q[rb];
        tx_time_q    <= time_q[rb];
        tx_channel_q <= ch_q[rb];
      end
    end

`ifdef UDP_BUF_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        tx_timeout_q;

  assign wd_hit = (rd_st == R_BUSY) && !bus.tx_done && (wd_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_cnt       <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      wd_cnt       <= (rd_st == R_BUSY) ? wd_cnt + 1'b1 : '0;
      tx_timeout_q <= wd_hit;
    end

  assign bus.tx_timeout = tx_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign wd_hit         = 1'b0;
  assign bus.tx_timeout = 1'b0;
`endif

  assign bus.tx_start   = (rd_st == R_START);
  assign bus.tx_length  = tx_length_q;
  assign bus.tx_time    = tx_time_q;
  assign bus.tx_channel = tx_channel_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_cnt_q;

  udp_buf_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr ({wb, wr_word}),
    .wdata (bus.in_data),
    .raddr ({rb, bus.rd_adr}),
    .rdata (bus.rd_data)
  );
endmodule

// File: tb/tb_udp_payload_buffer.sv
// Randomized bench for udp_payload_buffer against a packet-queue reference model.
module tb_udp_payload_buffer;
  localparam int AW  = 4;
  localparam int PKT = 4;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_payload_buffer_if #(.ADDR_W(AW)) u_if();
  udp_payload_buffer #(.ADDR_W(AW), .PKT_WORDS(PKT), .TIMEOUT_CYC(TO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // A closed packet: its words, metadata and the cycle it closed in.
  typedef struct {
    logic [PKT-1:0][31:0] w;
    int                   n;
    logic [31:0]          t;
    logic [7:0]           ch;
    int                   cc;
  } pkt_t;

  pkt_t        pend[$];
  pkt_t        cur;
  bit          open_p, active, hold, rd_pend;
  int          total, bad, cyc, drops, st_cyc, done_cyc, last_done, n_start, n_to, to_exp;
  logic [31:0] rd_exp;
  logic [15:0] cap_len;
  logic [31:0] cap_time;
  logic [7:0]  cap_ch;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs of cycle cyc, drive its inputs, advance the model.
  task automatic step(input bit v, input bit l, input logic [31:0] d,
                      input logic [7:0] ch, input logic [31:0] t);
    bit exp_start, rel;
    int due, a;
    exp_start = 1'b0;
    if (!active && pend.size() > 0) begin
      due = (pend[0].cc + 2 > last_done + 3) ? pend[0].cc + 2 : last_done + 3;
      exp_start = (cyc == due);
    end
    chk("tx_start", u_if.tx_start, exp_start);
    if (u_if.tx_start) begin
      n_start++;
      cap_len  = u_if.tx_length;
      cap_time = u_if.tx_time;
      cap_ch   = u_if.tx_channel;
    end
    if (exp_start) begin
      chk("tx_length", u_if.tx_length, 64'(pend[0].n * 4));
      chk("tx_time", u_if.tx_time, pend[0].t);
      chk("tx_channel", u_if.tx_channel, pend[0].ch);
      active   = 1'b1;
      st_cyc   = cyc;
      done_cyc = cyc + int'($urandom_range(1, 12));
    end else if (active) begin
      chk("tx_len_hold", u_if.tx_length, 64'(pend[0].n * 4));
    end
    chk("drop_cnt", u_if.drop_cnt, drops);
    chk("overflow", u_if.overflow, drops > 0);
`ifdef UDP_BUF_TIMEOUT_EN
    chk("tx_timeout", u_if.tx_timeout, cyc == to_exp);
    if (u_if.tx_timeout) n_to++;
`else
    chk("tx_timeout", u_if.tx_timeout, 1'b0);
`endif
    if (rd_pend) chk("rd_data", u_if.rd_data, rd_exp);

    u_if.in_valid   = v;
    u_if.in_last    = l;
    u_if.in_data    = d;
    u_if.in_channel = ch;
    u_if.time_now   = t;
    u_if.tx_done    = active && !hold && cyc == done_cyc && cyc > st_cyc;
    rd_pend = active && cyc > st_cyc;
    if (rd_pend) begin
      a = int'($urandom_range(0, pend[0].n - 1));
      u_if.rd_adr = AW'(a);
      rd_exp = pend[0].w[a];
    end else begin
      u_if.rd_adr = AW'($urandom);
    end

    // A word needs a free bank unless a packet is already open.
    if (v) begin
      if (!open_p && pend.size() == 2) drops++;
      else begin
        if (!open_p) begin
          open_p = 1'b1;
          cur.n  = 0;
          cur.t  = t;
          cur.ch = ch;
        end
        cur.w[cur.n] = d;
        cur.n++;
      end
    end
    if (open_p && (cur.n == PKT || l)) begin
      cur.cc = cyc;
      pend.push_back(cur);
      open_p = 1'b0;
    end
    rel = u_if.tx_done;
`ifdef UDP_BUF_TIMEOUT_EN
    if (active && hold && cyc == st_cyc + TO) begin
      rel    = 1'b1;
      to_exp = cyc + 1;
    end
`endif
    if (rel) begin
      void'(pend.pop_front());
      active    = 1'b0;
      last_done = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h0, 32'h0);
  endtask

  task automatic do_reset();
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    u_if.tx_done  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_start", u_if.tx_start, 1'b0);
    chk("rst_tx_length", u_if.tx_length, 16'h0);
    chk("rst_tx_time", u_if.tx_time, 32'h0);
    chk("rst_tx_channel", u_if.tx_channel, 8'h0);
    chk("rst_rd_data", u_if.rd_data, 32'h0);
    chk("rst_overflow", u_if.overflow, 1'b0);
    chk("rst_drop_cnt", u_if.drop_cnt, 16'h0);
    chk("rst_tx_timeout", u_if.tx_timeout, 1'b0);
    pend.delete();
    open_p    = 1'b0;
    active    = 1'b0;
    rd_pend   = 1'b0;
    drops     = 0;
    last_done = -100;
    to_exp    = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s;
    total = 0; bad = 0; cyc = 0; n_start = 0; n_to = 0;
    hold = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_last = 1'b0; u_if.in_data = '0;
    u_if.in_channel = '0; u_if.time_now = '0; u_if.rd_adr = '0; u_if.tx_done = 1'b0;
    @(negedge clk);
    do_reset();
    idle(3);

    // Single full packet; metadata comes from the first word only.
    cap_len = '0; cap_time = '0; cap_ch = '0;
    step(1'b1, 1'b0, 32'h11, 8'd3, 32'h1000);
    step(1'b1, 1'b0, 32'h22, 8'd9, 32'h1001);
    step(1'b1, 1'b0, 32'h33, 8'd9, 32'h1002);
    step(1'b1, 1'b0, 32'h44, 8'd9, 32'h1003);
    idle(20);
    chk("t1_len", cap_len, 16'd16);
    chk("t1_time", cap_time, 32'h1000);
    chk("t1_ch", cap_ch, 8'd3);

    // Short packet closed by a bare in_last; bare in_last with nothing open is ignored.
    cap_len = '0;
    step(1'b1, 1'b0, 32'hA1, 8'd5, 32'h2000);
    step(1'b1, 1'b0, 32'hA2, 8'd5, 32'h2001);
    step(1'b0, 1'b1, 32'h0, 8'd0, 32'h0);
    idle(20);
    chk("t2_len", cap_len, 16'd8);
    s = n_start;
    step(1'b0, 1'b1, 32'h0, 8'd0, 32'h0);
    idle(10);
    chk("t2_empty_last", n_start - s, 0);

    // Both banks full with the sender stalled: three words dropped.
    hold = 1'b1;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, $urandom, 8'd7, 32'h3000 + i);
    chk("t3_drops", u_if.drop_cnt, 16'd3);
    chk("t3_ovf", u_if.overflow, 1'b1);
    hold = 1'b0;
    done_cyc = cyc;
    s = n_start;
    idle(4);
    chk("t3_restart", n_start - s, 1);
    idle(20);

    // Reset while the sender is busy.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom, 8'd2, 32'h4000);
    for (int k = 0; k < 20 && !(active && cyc > st_cyc); k++) idle(1);
    do_reset();
    hold = 1'b0;
    s = n_start;
    idle(10);
    chk("t5_no_start", n_start - s, 0);

    // Release and close landing in the same cycle.
    s = n_start;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom, 8'd1, 32'h5000);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, 8'd2, 32'h6000);
    hold = 1'b0;
    done_cyc = cyc;
    step(1'b1, 1'b0, $urandom, 8'd2, 32'h6003);
    idle(20);
    chk("t4_starts", n_start - s, 2);
    chk("t4_drops", u_if.drop_cnt, 16'd0);

    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 12, $urandom, 8'($urandom), $urandom);
    idle(30);

`ifdef UDP_BUF_TIMEOUT_EN
    // Stalled sender: each bank is force-released by the watchdog.
    hold = 1'b1;
    s = n_to;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom, 8'd4, 32'h7000 + i);
    idle(60);
    chk("to_pulses", n_to - s, 2);
    hold = 1'b0;
    idle(5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
